// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl
//   Scrub scheduler for a bank of DEPTH triplicated register words. Walks the
//   bank round-robin, reads all three copies of a word, forms the bitwise
//   majority vote and rewrites the voted value when any copy disagrees. Shares
//   the bank's single access port with functional writes and keeps
//   corrected-error statistics.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         scrub enable
//   clr_i        synchronous clear of err_cnt_o / multi_err_o
//   wr_req_i     functional write request (held stable until granted)
//   wr_addr_i    functional write address
//   wr_data_i    functional write data
//   wr_gnt_o     functional write accepted this cycle (combinational)
//   arr_addr_o   bank address
//   arr_rd_o     bank read strobe; rd_*_i valid the following cycle
//   arr_we_o     bank write strobe; arr_wdata_o goes to all three copies
//   arr_wdata_o  bank write data
//   rd_a_i/rd_b_i/rd_c_i  copy A/B/C read data
//   err_cnt_o    corrected words since reset/clear, saturating
//   err_event_o  one-cycle pulse per corrected word
//   multi_err_o  sticky: more than one copy disagreed with the vote
//   busy_o       scrub step in progress
//
// state | meaning
// IDLE  | interval timer runs while enabled; functional writes granted
// RD    | read strobe to word ptr; port owned by scrubber
// VOTE  | read data valid: vote, decide FIX; functional writes granted
// FIX   | rewrite voted value to word ptr, count the correction

module tmr_scrub_ctrl #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int INTERVAL = 255,
   parameter int CNT_W    = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   output logic              wr_gnt_o,
   output logic [ADDR_W-1:0] arr_addr_o,
   output logic              arr_rd_o,
   output logic              arr_we_o,
   output logic [WIDTH-1:0]  arr_wdata_o,
   input  logic [WIDTH-1:0]  rd_a_i,
   input  logic [WIDTH-1:0]  rd_b_i,
   input  logic [WIDTH-1:0]  rd_c_i,
   output logic [CNT_W-1:0]  err_cnt_o,
   output logic              err_event_o,
   output logic              multi_err_o,
   output logic              busy_o
);

   localparam int TMR_W = (INTERVAL < 2) ? 1 : $clog2(INTERVAL + 1);
   localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(INTERVAL);
   localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      VOTE = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [WIDTH-1:0]  vote_q, vote_d;
   logic              multi_q, multi_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              multi_err_q, multi_err_d;

   logic [WIDTH-1:0]  vote_w;
   logic              bad_a, bad_b, bad_c;
   logic              mism_w, multi_w;
   logic [ADDR_W-1:0] ptr_next;

   assign vote_w   = (rd_a_i & rd_b_i) | (rd_a_i & rd_c_i) | (rd_b_i & rd_c_i);
   assign bad_a    = (rd_a_i != vote_w);
   assign bad_b    = (rd_b_i != vote_w);
   assign bad_c    = (rd_c_i != vote_w);
   assign mism_w   = bad_a | bad_b | bad_c;
   assign multi_w  = (bad_a & bad_b) | (bad_a & bad_c) | (bad_b & bad_c);
   assign ptr_next = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         timer_q     <= TMR_RELOAD;
         vote_q      <= '0;
         multi_q     <= 1'b0;
         err_cnt_q   <= '0;
         multi_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         timer_q     <= timer_d;
         vote_q      <= vote_d;
         multi_q     <= multi_d;
         err_cnt_q   <= err_cnt_d;
         multi_err_q <= multi_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      timer_d     = timer_q;
      vote_d      = vote_q;
      multi_d     = multi_q;
      err_cnt_d   = err_cnt_q;
      multi_err_d = multi_err_q;
      wr_gnt_o    = 1'b0;
      arr_addr_o  = '0;
      arr_rd_o    = 1'b0;
      arr_we_o    = 1'b0;
      arr_wdata_o = '0;
      err_event_o = 1'b0;
      busy_o      = 1'b0;

      case (state_q)
         IDLE: begin
            wr_gnt_o = wr_req_i;
            if (en_i) begin
               if (timer_q == '0) begin
                  state_d = RD;
                  timer_d = TMR_RELOAD;
               end else begin
                  timer_d = timer_q - TMR_W'(1);
               end
            end
         end
         RD: begin
            busy_o     = 1'b1;
            arr_rd_o   = 1'b1;
            arr_addr_o = ptr_q;
            state_d    = VOTE;
         end
         VOTE: begin
            busy_o   = 1'b1;
            wr_gnt_o = wr_req_i;
            vote_d   = vote_w;
            multi_d  = multi_w;
            // A functional write to the word under scrub supersedes the repair.
            if (wr_req_i && (wr_addr_i == ptr_q)) begin
               ptr_d   = ptr_next;
               state_d = IDLE;
            end else if (mism_w) begin
               state_d = FIX;
            end else begin
               ptr_d   = ptr_next;
               state_d = IDLE;
            end
         end
         FIX: begin
            busy_o      = 1'b1;
            arr_we_o    = 1'b1;
            arr_addr_o  = ptr_q;
            arr_wdata_o = vote_q;
            err_event_o = 1'b1;
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            multi_err_d = multi_err_q | multi_q;
            ptr_d       = ptr_next;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (wr_gnt_o) begin
         arr_we_o    = 1'b1;
         arr_addr_o  = wr_addr_i;
         arr_wdata_o = wr_data_i;
      end

      // Clear beats a same-cycle increment, but a same-cycle multi still sticks.
      if (clr_i) begin
         err_cnt_d   = '0;
         multi_err_d = (state_q == FIX) & multi_q;
      end
   end

   assign err_cnt_o   = err_cnt_q;
   assign multi_err_o = multi_err_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb_tmr_scrub_ctrl
//   Bench for tmr_scrub_ctrl with INTERVAL=3. A bank model answers the
//   scrubber's reads and writes; a shadow copy of the bank plus a majority
//   function predict every scrub step, correction and counter value.

module tb_tmr_scrub_ctrl;

   localparam int INTERVAL = 3;
   localparam int DEPTH    = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, clr, wr_req;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_gnt;
   logic [3:0] arr_addr;
   logic       arr_rd, arr_we;
   logic [7:0] arr_wdata;
   logic [7:0] rd_a, rd_b, rd_c;
   logic [7:0] err_cnt;
   logic       err_event, multi_err, busy;

   always #5 clk = ~clk;

   tmr_scrub_ctrl #(
      .WIDTH(8), .DEPTH(DEPTH), .ADDR_W(4), .INTERVAL(INTERVAL), .CNT_W(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr),
      .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
      .arr_addr_o(arr_addr), .arr_rd_o(arr_rd), .arr_we_o(arr_we), .arr_wdata_o(arr_wdata),
      .rd_a_i(rd_a), .rd_b_i(rd_b), .rd_c_i(rd_c),
      .err_cnt_o(err_cnt), .err_event_o(err_event), .multi_err_o(multi_err), .busy_o(busy)
   );

   // Bank model: error injection first, then a DUT write to the same word wins.
   logic [7:0] ma [DEPTH] = '{default: 8'h00};
   logic [7:0] mb [DEPTH] = '{default: 8'h00};
   logic [7:0] mc [DEPTH] = '{default: 8'h00};
   logic       inj_v = 1'b0;
   logic [3:0] inj_addr = 4'd0;
   logic [7:0] inj_a = 8'h00, inj_b = 8'h00, inj_c = 8'h00;
   int         cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (inj_v) begin
         ma[inj_addr] <= inj_a;
         mb[inj_addr] <= inj_b;
         mc[inj_addr] <= inj_c;
      end
      if (arr_we) begin
         ma[arr_addr] <= arr_wdata;
         mb[arr_addr] <= arr_wdata;
         mc[arr_addr] <= arr_wdata;
      end
      if (arr_rd) begin
         rd_a <= ma[arr_addr];
         rd_b <= mb[arr_addr];
         rd_c <= mc[arr_addr];
      end
   end

   // Reference state
   logic [7:0] sh_a [DEPTH];
   logic [7:0] sh_b [DEPTH];
   logic [7:0] sh_c [DEPTH];
   int exp_ptr, exp_cnt, exp_gap, last_cyc;
   bit exp_multi, have_last;
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] maj(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
      end
      return r;
   endfunction

   task automatic inject(input int addr, input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic);
      inj_addr = 4'(addr);
      inj_a = ia; inj_b = ib; inj_c = ic;
      inj_v = 1'b1;
      @(posedge clk);
      #1 inj_v = 1'b0;
      sh_a[addr] = ia; sh_b[addr] = ib; sh_c[addr] = ic;
      @(negedge clk);
   endtask

   task automatic wait_rd(output int n);
      n = 0;
      while (!arr_rd && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("rd_seen", 32'(arr_rd), 32'd1);
   endtask

   // Called at the negedge where arr_rd is high; ends at the first IDLE negedge.
   task automatic finish_step(input bit do_clr);
      logic [7:0] v;
      int nbad;
      chk("rd_addr", 32'(arr_addr), 32'(exp_ptr));
      if (have_last) chk("rd_gap", 32'(cyc - last_cyc), 32'(exp_gap));
      last_cyc  = cyc;
      have_last = 1'b1;
      v    = maj(sh_a[exp_ptr], sh_b[exp_ptr], sh_c[exp_ptr]);
      nbad = int'(sh_a[exp_ptr] != v) + int'(sh_b[exp_ptr] != v) + int'(sh_c[exp_ptr] != v);
      @(negedge clk);
      chk("vote_busy", 32'(busy), 32'd1);
      chk("vote_no_we", 32'(arr_we), 32'd0);
      if (nbad > 0) begin
         @(negedge clk);
         chk("fix_we", 32'(arr_we), 32'd1);
         chk("fix_addr", 32'(arr_addr), 32'(exp_ptr));
         chk("fix_data", 32'(arr_wdata), 32'(v));
         chk("fix_event", 32'(err_event), 32'd1);
         if (do_clr) clr = 1'b1;
         @(negedge clk);
         clr = 1'b0;
         exp_cnt   = do_clr ? 0 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
         exp_multi = (do_clr ? 1'b0 : exp_multi) | (nbad >= 2);
         sh_a[exp_ptr] = v; sh_b[exp_ptr] = v; sh_c[exp_ptr] = v;
         exp_gap = INTERVAL + 4;
      end else begin
         @(negedge clk);
         exp_gap = INTERVAL + 3;
      end
      chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      chk("multi_err", 32'(multi_err), 32'(exp_multi));
      chk("event_low", 32'(err_event), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      exp_ptr = (exp_ptr + 1) % DEPTH;
   endtask

   task automatic step(input bit inj, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] ic, input bit do_clr);
      int n;
      if (inj) inject(exp_ptr, ia, ib, ic);
      wait_rd(n);
      finish_step(do_clr);
   endtask

   task automatic skip_to(input int target);
      int guard = 0;
      while (exp_ptr != target && guard < DEPTH) begin
         step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
         guard++;
      end
   endtask

   initial begin : watchdog
      #400us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n, guard;
      bit seen;
      logic [7:0] base, m1, m2;
      for (int i = 0; i < DEPTH; i++) begin
         sh_a[i] = 8'h00; sh_b[i] = 8'h00; sh_c[i] = 8'h00;
      end
      exp_ptr = 0; exp_cnt = 0; exp_gap = 0; last_cyc = 0;
      exp_multi = 1'b0; have_last = 1'b0;
      rst_n = 1'b0; en = 1'b1; clr = 1'b0;
      wr_req = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_arr_rd", 32'(arr_rd), 32'd0);
      chk("rst_arr_we", 32'(arr_we), 32'd0);
      chk("rst_arr_addr", 32'(arr_addr), 32'd0);
      chk("rst_arr_wdata", 32'(arr_wdata), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_err_event", 32'(err_event), 32'd0);
      chk("rst_multi_err", 32'(multi_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Clean walk: first read after INTERVAL+1 cycles, then full wrap
      rst_n = 1'b1;
      wait_rd(n);
      chk("first_rd_latency", 32'(n), 32'(INTERVAL + 1));
      finish_step(1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

      // Single-copy error on word 5
      skip_to(5);
      step(1'b1, 8'h3C, 8'h3C, 8'h00, 1'b0);

      // Two copies disagree on word 2 -> multi_err sticks until clr
      skip_to(2);
      step(1'b1, 8'h01, 8'h02, 8'h03, 1'b0);
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      chk("multi_sticky", 32'(multi_err), 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_cnt = 0; exp_multi = 1'b0;
      chk("clr_cnt", 32'(err_cnt), 32'd0);
      chk("clr_multi", 32'(multi_err), 32'd0);

      // Functional write to the word under scrub cancels the repair
      skip_to(7);
      inject(7, 8'h11, 8'h11, 8'h10);
      wait_rd(n);
      chk("col_rd_addr", 32'(arr_addr), 32'd7);
      if (have_last) chk("col_rd_gap", 32'(cyc - last_cyc), 32'(exp_gap));
      last_cyc = cyc;
      wr_req = 1'b1; wr_addr = 4'd7; wr_data = 8'hAA;
      #1 chk("col_gnt_rd", 32'(wr_gnt), 32'd0);
      @(negedge clk);
      chk("col_gnt_vote", 32'(wr_gnt), 32'd1);
      chk("col_we", 32'(arr_we), 32'd1);
      chk("col_addr", 32'(arr_addr), 32'd7);
      chk("col_data", 32'(arr_wdata), 32'hAA);
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      chk("col_no_fix", 32'(arr_we), 32'd0);
      chk("col_no_event", 32'(err_event), 32'd0);
      chk("col_idle", 32'(busy), 32'd0);
      chk("col_cnt", 32'(err_cnt), 32'(exp_cnt));
      sh_a[7] = 8'hAA; sh_b[7] = 8'hAA; sh_c[7] = 8'hAA;
      exp_ptr = 8; exp_gap = INTERVAL + 3;

      // Scrub disabled: no reads, timer holds
      en = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (arr_rd) seen = 1'b1;
      end
      chk("en_off_no_rd", 32'(seen), 32'd0);
      en = 1'b1;
      have_last = 1'b0;
      wait_rd(n);
      chk("en_on_latency", 32'(n), 32'(INTERVAL + 1));
      finish_step(1'b0);

      // Random corruption patterns
      for (int i = 0; i < 40; i++) begin
         base = 8'($urandom);
         m1   = 8'($urandom_range(1, 255));
         m2   = 8'($urandom_range(1, 255));
         case ($urandom_range(0, 3))
            0: step(1'b1, base, base, base, 1'b0);
            1: step(1'b1, base, base ^ m1, base, 1'b0);
            2: step(1'b1, base ^ m1, base, base ^ m2, 1'b0);
            default: step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
         endcase
      end

      // Saturation of err_cnt
      guard = 0;
      while (exp_cnt != 255 && guard < 300) begin
         base = 8'($urandom);
         step(1'b1, base, base, base ^ 8'h01, 1'b0);
         guard++;
      end
      chk("sat_reached", 32'(err_cnt), 32'hFF);
      step(1'b1, 8'h5A, 8'h5B, 8'h5A, 1'b0);
      chk("sat_hold", 32'(err_cnt), 32'hFF);

      // clr together with a multi-copy correction
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_cnt = 0; exp_multi = 1'b0;
      step(1'b1, 8'h0F, 8'hF0, 8'hFF, 1'b0);
      step(1'b1, 8'h01, 8'h02, 8'h04, 1'b1);
      chk("clr_win_cnt", 32'(err_cnt), 32'd0);
      chk("clr_multi_set", 32'(multi_err), 32'd1);

      // Reset in the middle of FIX
      step(1'b1, 8'h77, 8'h76, 8'h77, 1'b0);
      inject(exp_ptr, 8'h33, 8'h33, 8'h30);
      wait_rd(n);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_we", 32'(arr_we), 32'd1);
      chk("pre_rst_cnt_nz", 32'(err_cnt != 8'h00), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_we", 32'(arr_we), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_cnt", 32'(err_cnt), 32'd0);
      chk("async_multi", 32'(multi_err), 32'd0);
      chk("async_event", 32'(err_event), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_ptr = 0; exp_cnt = 0; exp_multi = 1'b0; have_last = 1'b0;
      wait_rd(n);
      chk("post_rst_latency", 32'(n), 32'(INTERVAL + 1));
      finish_step(1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
